// File: rtl/fir_seq_pkg.sv
// Shared constants and state encoding for the FIR tap sequencer.
// Decode points are offsets within one 20-cycle sample period.
package fir_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int P_GROUPS = 4;
   localparam int P_TAPS   = 10;
   localparam int P_PERIOD = 20;

   localparam int COEF_NUM  = P_GROUPS * P_TAPS;
   localparam int MAC_FIRST = 2;
   localparam int MAC_LAST  = MAC_FIRST + P_TAPS - 1;
   localparam int SUM_CYC   = MAC_LAST + 1;
   localparam int WIN_FIRST = SUM_CYC + 1;

endpackage

// File: rtl/fir_seq_period_cnt.sv
// Modulo-P_PERIOD cycle counter with synchronous clear and count enable;
// oTc flags the last cycle of the period.
module fir_seq_period_cnt #(
   parameter int P_PERIOD = 20,
   parameter int CNT_W    = $clog2(P_PERIOD)
) (
   input  logic             iClk12M,
   input  logic             iRst,
   input  logic             iClr,
   input  logic             iEn,
   output logic [CNT_W-1:0] oCnt,
   output logic             oTc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign oTc  = (cnt_q == CNT_W'(P_PERIOD - 1));
   assign oCnt = cnt_q;

   // NOTE: next-state holds its value by default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (iClr) begin
         cnt_d = '0;
      end else if (iEn) begin
         cnt_d = oTc ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sample strobe, tap-index sequencing and coefficient-write arbitration for the 40-tap FIR.
// Optional FIR_SEQ_SAMPLE_CNT_EN adds a 16-bit count of completed group sums on oSampleCnt.
module fir_tap_sequencer #(
   parameter int P_PERIOD = 20,
   parameter int P_TAPS   = 10,
   parameter int P_COEF_W = 3
) (
   input  logic                      iClk12M,
   input  logic                      iRst,
   input  logic                      iEnable,
   input  logic                      iCoeffWrReq,
   input  logic [5:0]                iCoeffWrAddr,
   input  logic [P_COEF_W-1:0]       iCoeffWrData,
   output logic                      oEnSample600k,
   output logic [$clog2(P_TAPS)-1:0] oTapSel,
   output logic                      oEnMac,
   output logic                      oAccClr,
   output logic                      oEnSum,
   output logic                      oCoeffWe,
   output logic [5:0]                oCoeffWrAddr,
   output logic [P_COEF_W-1:0]       oCoeffWrData,
   output logic                      oCoeffWrAck,
   output logic                      oBusy
`ifdef FIR_SEQ_SAMPLE_CNT_EN
   ,
   output logic [15:0]               oSampleCnt
`endif
);

   import fir_seq_pkg::*;

   localparam int CNT_W = $clog2(P_PERIOD);
   localparam int TAP_W = $clog2(P_TAPS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;
   logic             run;
   logic             win;

   assign run   = (state_q == ST_RUN);
   assign oBusy = run;

   fir_seq_period_cnt #(
      .P_PERIOD (P_PERIOD),
      .CNT_W    (CNT_W)
   ) u_period_cnt (
      .iClk12M (iClk12M),
      .iRst    (iRst),
      .iClr    (!run),
      .iEn     (run),
      .oCnt    (cnt),
      .oTc     (cnt_tc)
   );

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A run request is only honoured at period boundaries, so periods are never truncated.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (iEnable)           state_d = ST_RUN;
         ST_RUN:  if (cnt_tc && !iEnable) state_d = ST_IDLE;
         default:                         state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      oEnSample600k = 1'b0;
      oEnMac        = 1'b0;
      oAccClr       = 1'b0;
      oEnSum        = 1'b0;
      oTapSel       = '0;
      if (run) begin
         oEnSample600k = (cnt == CNT_W'(0));
         oEnMac        = (cnt >= CNT_W'(MAC_FIRST)) && (cnt <= CNT_W'(MAC_LAST));
         oAccClr       = (cnt == CNT_W'(MAC_FIRST));
         oEnSum        = (cnt == CNT_W'(SUM_CYC));
         if (oEnMac) oTapSel = TAP_W'(cnt - CNT_W'(MAC_FIRST));
      end
   end

   // Writes land only while no MAC reads the coefficient RAM; out-of-range addresses are acked and dropped.
   assign win          = !run || (cnt >= CNT_W'(WIN_FIRST));
   assign oCoeffWrAck  = iCoeffWrReq & win & ~iRst;
   assign oCoeffWe     = oCoeffWrAck & (iCoeffWrAddr < 6'(COEF_NUM));
   assign oCoeffWrAddr = oCoeffWe ? iCoeffWrAddr : '0;
   assign oCoeffWrData = oCoeffWe ? iCoeffWrData : '0;

`ifdef FIR_SEQ_SAMPLE_CNT_EN
   logic [15:0] sample_cnt_q;

   always_ff @(posedge iClk12M or posedge iRst) begin
      if (iRst) begin
         sample_cnt_q <= '0;
      end else if (oEnSum) begin
         sample_cnt_q <= sample_cnt_q + 16'd1;
      end
   end

   assign oSampleCnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: a cycle-arithmetic reference model predicts every
// output vector and every accepted write; a separate monitor pops and compares them.
module tb_fir_tap_sequencer;

   localparam int PERIOD = 20;

   logic       clk = 1'b0;
   logic       rst, en, req;
   logic [5:0] addr;
   logic [2:0] data;

   logic       o_strobe, o_mac, o_clr, o_sum, o_we, o_ack, o_busy;
   logic [3:0] o_tap;
   logic [5:0] o_waddr;
   logic [2:0] o_wdata;
`ifdef FIR_SEQ_SAMPLE_CNT_EN
   logic [15:0] o_scnt;
`endif

   always #5 clk = ~clk;

   fir_tap_sequencer dut (
      .iClk12M       (clk),
      .iRst          (rst),
      .iEnable       (en),
      .iCoeffWrReq   (req),
      .iCoeffWrAddr  (addr),
      .iCoeffWrData  (data),
      .oEnSample600k (o_strobe),
      .oTapSel       (o_tap),
      .oEnMac        (o_mac),
      .oAccClr       (o_clr),
      .oEnSum        (o_sum),
      .oCoeffWe      (o_we),
      .oCoeffWrAddr  (o_waddr),
      .oCoeffWrData  (o_wdata),
      .oCoeffWrAck   (o_ack),
      .oBusy         (o_busy)
`ifdef FIR_SEQ_SAMPLE_CNT_EN
      ,
      .oSampleCnt    (o_scnt)
`endif
   );

   typedef struct packed {
      logic        strobe;
      logic [3:0]  tap;
      logic        mac;
      logic        clr;
      logic        sum;
      logic        busy;
      logic        ack;
      logic        we;
      logic [5:0]  waddr;
      logic [2:0]  wdata;
      logic [15:0] scnt;
   } vec_t;

   typedef struct packed {
      logic [5:0] a;
      logic [2:0] d;
      logic       we;
   } wr_t;

   vec_t exp_q[$];
   wr_t  wr_q[$];
   vec_t last_e;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int timeouts = 0;
   bit done = 1'b0;

   // Reference model: run flag, cycle at which the current run started, sample count
   bit          m_run = 1'b0;
   int          m_t0 = 0;
   logic [15:0] m_scnt = '0;

   // Host-side values applied on the next cycle
   logic       n_rst, n_en, n_req;
   logic [5:0] n_addr;
   logic [2:0] n_data;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   function automatic vec_t got_vec();
      vec_t g;
      g.strobe = o_strobe;
      g.tap    = o_tap;
      g.mac    = o_mac;
      g.clr    = o_clr;
      g.sum    = o_sum;
      g.busy   = o_busy;
      g.ack    = o_ack;
      g.we     = o_we;
      g.waddr  = o_waddr;
      g.wdata  = o_wdata;
`ifdef FIR_SEQ_SAMPLE_CNT_EN
      g.scnt   = o_scnt;
`else
      g.scnt   = '0;
`endif
      return g;
   endfunction

   function automatic int phase();
      return (cyc - m_t0) % PERIOD;
   endfunction

   // One clock: advance the model on the edge, apply the next inputs, predict this cycle's outputs.
   task automatic cycle();
      vec_t e;
      int   ph;
      bit   win;
      @(posedge clk);
      if (rst) begin
         m_run  = 1'b0;
         m_scnt = '0;
      end else begin
         if (last_e.sum) m_scnt = m_scnt + 16'd1;
         if (!m_run) begin
            if (en) begin
               m_run = 1'b1;
               m_t0  = cyc + 1;
            end
         end else if (phase() == PERIOD - 1 && !en) begin
            m_run = 1'b0;
         end
      end
      cyc++;
      #1;
      rst  = n_rst;
      en   = n_en;
      req  = n_req;
      addr = n_addr;
      data = n_data;
      if (rst) begin
         m_run  = 1'b0;
         m_scnt = '0;
      end
      ph = phase();
      e  = '0;
      e.busy = m_run;
      if (m_run) begin
         e.strobe = (ph == 0);
         e.mac    = (ph >= 2 && ph <= 11);
         e.tap    = e.mac ? 4'(ph - 2) : 4'd0;
         e.clr    = (ph == 2);
         e.sum    = (ph == 12);
      end
      win   = !m_run || ph >= 13;
      e.ack = req && win && !rst;
      e.we  = e.ack && (addr < 6'd40);
      if (e.we) begin
         e.waddr = addr;
         e.wdata = data;
      end
`ifdef FIR_SEQ_SAMPLE_CNT_EN
      e.scnt = m_scnt;
`endif
      exp_q.push_back(e);
      if (e.ack) wr_q.push_back({e.waddr, e.wdata, e.we});
      last_e = e;
   endtask

   task automatic run_to_phase(input int p);
      int n = 0;
      do begin
         cycle();
         n++;
      end while (!(m_run && phase() == p) && n < 60);
      if (!(m_run && phase() == p)) timeouts++;
   endtask

   // Host raises a request and holds it stable until the cycle it is acknowledged.
   task automatic post_write(input logic [5:0] a, input logic [2:0] d);
      int n = 0;
      n_req  = 1'b1;
      n_addr = a;
      n_data = d;
      do begin
         cycle();
         n++;
      end while (!last_e.ack && n < 40);
      if (!last_e.ack) timeouts++;
      n_req  = 1'b0;
      n_addr = '0;
      n_data = '0;
   endtask

   initial begin
      vec_t e;
      wr_t  w;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", got_vec(), e);
         end
         if (o_ack) begin
            if (wr_q.size() == 0) begin
               check("wr_spurious_ack", 64'(o_ack), 64'd0);
            end else begin
               w = wr_q.pop_front();
               check("wr_port", {o_waddr, o_wdata, o_we}, w);
            end
         end
         if (done) begin
            check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
            check("bounded_waits", 64'(timeouts), 64'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      end
   end

   initial begin
      last_e = '0;
      n_rst = 1'b1; n_en = 1'b0; n_req = 1'b0; n_addr = '0; n_data = '0;
      rst   = 1'b1; en   = 1'b0; req   = 1'b0; addr   = '0; data   = '0;
      repeat (3) cycle();

      // Start-up: strobes every 20 cycles, a write held off from rCnt=4 until the window
      n_rst = 1'b0;
      n_en  = 1'b1;
      cycle();
      run_to_phase(3);
      post_write(6'd17, 3'd3);
      repeat (30) cycle();

      // Drop the run request mid-period: the period finishes, then IDLE
      run_to_phase(4);
      n_en = 1'b0;
      repeat (30) cycle();

      // Back-to-back writes in IDLE, then an out-of-range address
      post_write(6'd0, 3'($urandom));
      post_write(6'd1, 3'($urandom));
      post_write(6'd2, 3'($urandom));
      post_write(6'd45, 3'($urandom));
      repeat (2) cycle();

      // Asynchronous reset mid-period, then a clean restart
      n_en = 1'b1;
      run_to_phase(6);
      n_rst = 1'b1;
      repeat (2) cycle();
      n_rst = 1'b0;
      n_en  = 1'b1;
      repeat (25) cycle();

      // Stop request together with a write at the last period cycle
      run_to_phase(18);
      n_en = 1'b0;
      post_write(6'd9, 3'd5);
      repeat (3) cycle();

`ifdef FIR_SEQ_SAMPLE_CNT_EN
      // Preload the sample counter to its top value and let one sum wrap it
      @(negedge clk);
      #1;
      force dut.sample_cnt_q = 16'hFFFF;
      #1;
      release dut.sample_cnt_q;
      m_scnt = 16'hFFFF;
      n_en = 1'b1;
      repeat (25) cycle();
      n_en = 1'b0;
      repeat (25) cycle();
`endif

      // Randomized run requests and host writes
      for (int i = 0; i < 60; i++) begin
         n_en = ($urandom_range(0, 9) != 0);
         repeat ($urandom_range(0, 15)) cycle();
         if ($urandom_range(0, 1) == 1) post_write(6'($urandom_range(0, 63)), 3'($urandom));
      end
      repeat (2) cycle();
      done = 1'b1;
   end

endmodule
